// File: rtl/ctrl_pipe_hazard_if.sv
// Control bundle between the decode-stage controller, this hazard/pipeline
// block and the datapath. The master side drives the decode-stage fields and
// consumes the pipelined control, stalls, flushes and forwarding selects.
interface ctrl_pipe_hazard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  // Decode-stage bundle
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             MemWriteD;
  logic             ALUSrcD;
  logic             RegDstD;
  logic [2:0]       ALUControlD;
  logic             BranchD;
  logic             PCSrcD;
  logic             JumpD;
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RdD;

  // E stage
  logic             RegWriteE;
  logic             MemtoRegE;
  logic             MemWriteE;
  logic             ALUSrcE;
  logic             RegDstE;
  logic [2:0]       ALUControlE;
  logic [REG_W-1:0] RsE;
  logic [REG_W-1:0] RtE;
  logic [REG_W-1:0] RdE;
  logic [REG_W-1:0] WriteRegE;

  // M stage
  logic             RegWriteM;
  logic             MemtoRegM;
  logic             MemWriteM;
  logic [REG_W-1:0] WriteRegM;

  // W stage
  logic             RegWriteW;
  logic             MemtoRegW;
  logic [REG_W-1:0] WriteRegW;

  // Hazard unit results
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             PCRedirect;
  logic             ForwardAD;
  logic             ForwardBD;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
           BranchD, PCSrcD, JumpD, RsD, RtD, RdD,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RsE, RtE, RdE, WriteRegE,
           RegWriteM, MemtoRegM, MemWriteM, WriteRegM,
           RegWriteW, MemtoRegW, WriteRegW,
           StallF, StallD, FlushD, FlushE, PCRedirect,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, stall_cnt
  );

  modport slave (
    input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
           BranchD, PCSrcD, JumpD, RsD, RtD, RdD,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
           RsE, RtE, RdE, WriteRegE,
           RegWriteM, MemtoRegM, MemWriteM, WriteRegM,
           RegWriteW, MemtoRegW, WriteRegW,
           StallF, StallD, FlushD, FlushE, PCRedirect,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE, stall_cnt
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Carries decoded control through the E/M/W stage registers and resolves
// load-use and branch-operand hazards: stalls, flushes, redirect gating and
// forwarding selects. The stage registers themselves never stall; a stall
// holds F/D upstream and a bubble is injected into E instead.
module ctrl_pipe_hazard #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  ctrl_pipe_hazard_if.slave bus
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  logic             r_RegWriteE, r_MemtoRegE, r_MemWriteE, r_ALUSrcE, r_RegDstE;
  logic [2:0]       r_ALUControlE;
  logic [REG_W-1:0] r_RsE, r_RtE, r_RdE;
  logic             r_RegWriteM, r_MemtoRegM, r_MemWriteM;
  logic [REG_W-1:0] r_WriteRegM;
  logic             r_RegWriteW, r_MemtoRegW;
  logic [REG_W-1:0] r_WriteRegW;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [REG_W-1:0] w_WriteRegE;
  logic             w_lwstall, w_branchstall, w_stall, w_redirect;
  logic [1:0]       w_ForwardAE, w_ForwardBE;
  logic             w_ForwardAD, w_ForwardBD;

  // Operand select for E: the younger result in M beats the older one in W,
  // and register 0 is hard-wired so it never takes a forwarded value.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             wr_m,
                                         input logic [REG_W-1:0] dst_m,
                                         input logic             wr_w,
                                         input logic [REG_W-1:0] dst_w);
    if ((src != '0) && wr_m && (src == dst_m))      return FWD_M;
    else if ((src != '0) && wr_w && (src == dst_w)) return FWD_W;
    else                                             return FWD_RF;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Destination register and hazard / redirect / forwarding decisions.
  always_comb begin
    w_WriteRegE   = r_RegDstE ? r_RdE : r_RtE;
    w_lwstall     = r_MemtoRegE & ((r_RtE == bus.RsD) | (r_RtE == bus.RtD));
    w_branchstall = bus.BranchD &
                    ((r_RegWriteE & ((w_WriteRegE == bus.RsD) | (w_WriteRegE == bus.RtD))) |
                     (r_MemtoRegM & ((r_WriteRegM == bus.RsD) | (r_WriteRegM == bus.RtD))));
    w_stall       = w_lwstall | w_branchstall;
    // A stalled branch must not redirect; it re-evaluates once the stall clears.
    w_redirect    = (bus.PCSrcD | bus.JumpD) & ~w_stall;
    w_ForwardAE   = fwd_sel(r_RsE, r_RegWriteM, r_WriteRegM, r_RegWriteW, r_WriteRegW);
    w_ForwardBE   = fwd_sel(r_RtE, r_RegWriteM, r_WriteRegM, r_RegWriteW, r_WriteRegW);
    w_ForwardAD   = (bus.RsD != '0) & r_RegWriteM & (bus.RsD == r_WriteRegM);
    w_ForwardBD   = (bus.RtD != '0) & r_RegWriteM & (bus.RtD == r_WriteRegM);
  end

  // D -> E stage boundary: load the decode bundle or a bubble on a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_RegWriteE   <= 1'b0;
      r_MemtoRegE   <= 1'b0;
      r_MemWriteE   <= 1'b0;
      r_ALUSrcE     <= 1'b0;
      r_RegDstE     <= 1'b0;
      r_ALUControlE <= '0;
      r_RsE         <= '0;
      r_RtE         <= '0;
      r_RdE         <= '0;
    end else if (w_stall) begin
      r_RegWriteE   <= 1'b0;
      r_MemtoRegE   <= 1'b0;
      r_MemWriteE   <= 1'b0;
      r_ALUSrcE     <= 1'b0;
      r_RegDstE     <= 1'b0;
      r_ALUControlE <= '0;
      r_RsE         <= '0;
      r_RtE         <= '0;
      r_RdE         <= '0;
    end else begin
      r_RegWriteE   <= bus.RegWriteD;
      r_MemtoRegE   <= bus.MemtoRegD;
      r_MemWriteE   <= bus.MemWriteD;
      r_ALUSrcE     <= bus.ALUSrcD;
      r_RegDstE     <= bus.RegDstD;
      r_ALUControlE <= bus.ALUControlD;
      r_RsE         <= bus.RsD;
      r_RtE         <= bus.RtD;
      r_RdE         <= bus.RdD;
    end
  end

  // E -> M and M -> W stage boundaries: always advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_RegWriteM <= 1'b0;
      r_MemtoRegM <= 1'b0;
      r_MemWriteM <= 1'b0;
      r_WriteRegM <= '0;
      r_RegWriteW <= 1'b0;
      r_MemtoRegW <= 1'b0;
      r_WriteRegW <= '0;
    end else begin
      r_RegWriteM <= r_RegWriteE;
      r_MemtoRegM <= r_MemtoRegE;
      r_MemWriteM <= r_MemWriteE;
      r_WriteRegM <= w_WriteRegE;
      r_RegWriteW <= r_RegWriteM;
      r_MemtoRegW <= r_MemtoRegM;
      r_WriteRegW <= r_WriteRegM;
    end
  end

  // Count stalled cycles, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign bus.RegWriteE   = r_RegWriteE;
  assign bus.MemtoRegE   = r_MemtoRegE;
  assign bus.MemWriteE   = r_MemWriteE;
  assign bus.ALUSrcE     = r_ALUSrcE;
  assign bus.RegDstE     = r_RegDstE;
  assign bus.ALUControlE = r_ALUControlE;
  assign bus.RsE         = r_RsE;
  assign bus.RtE         = r_RtE;
  assign bus.RdE         = r_RdE;
  assign bus.WriteRegE   = w_WriteRegE;
  assign bus.RegWriteM   = r_RegWriteM;
  assign bus.MemtoRegM   = r_MemtoRegM;
  assign bus.MemWriteM   = r_MemWriteM;
  assign bus.WriteRegM   = r_WriteRegM;
  assign bus.RegWriteW   = r_RegWriteW;
  assign bus.MemtoRegW   = r_MemtoRegW;
  assign bus.WriteRegW   = r_WriteRegW;
  assign bus.StallF      = w_stall;
  assign bus.StallD      = w_stall;
  assign bus.FlushE      = w_stall;
  assign bus.PCRedirect  = w_redirect;
  assign bus.FlushD      = w_redirect;
  assign bus.ForwardAE   = w_ForwardAE;
  assign bus.ForwardBE   = w_ForwardBE;
  assign bus.ForwardAD   = w_ForwardAD;
  assign bus.ForwardBD   = w_ForwardBD;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: a hand-computed vector table, hand-written
// reset and counter-saturation sequences, then random traffic against a
// queue-based model of the instruction pipeline.
module tb_ctrl_pipe_hazard;

  logic clk;
  logic rst;

  ctrl_pipe_hazard_if #(.REG_W(5), .CNT_W(16)) ifc ();
  ctrl_pipe_hazard_if #(.REG_W(5), .CNT_W(2))  ifc2 ();

  ctrl_pipe_hazard #(.REG_W(5), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(ifc));
  ctrl_pipe_hazard #(.REG_W(5), .CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .bus(ifc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       as;
    logic       rdst;
    logic [2:0] aluc;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct {
    instr_t      d;
    logic        br, pcs, jmp;
    logic        stall, redir;
    logic [1:0]  fae, fbe;
    logic        fad, fbd;
    logic        rwE, m2rE;
    logic [4:0]  wrE;
    logic        rwM;
    logic [4:0]  wrM;
    logic [15:0] cnt;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: the instructions currently in E, M, W (index 0, 1, 2).
  instr_t      q[$];
  logic [15:0] m_cnt;

  function automatic instr_t ins(logic rw, logic m2r, logic mw, logic as, logic rdst,
                                 logic [2:0] aluc, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    instr_t b;
    b.rw = rw; b.m2r = m2r; b.mw = mw; b.as = as; b.rdst = rdst;
    b.aluc = aluc; b.rs = rs; b.rt = rt; b.rd = rd;
    return b;
  endfunction

  function automatic logic [4:0] dest(instr_t b);
    return b.rdst ? b.rd : b.rt;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input instr_t b, input logic br, input logic pcs, input logic jmp);
    ifc.RegWriteD = b.rw;  ifc.MemtoRegD = b.m2r; ifc.MemWriteD = b.mw;
    ifc.ALUSrcD = b.as;    ifc.RegDstD = b.rdst;  ifc.ALUControlD = b.aluc;
    ifc.RsD = b.rs;        ifc.RtD = b.rt;        ifc.RdD = b.rd;
    ifc.BranchD = br;      ifc.PCSrcD = pcs;      ifc.JumpD = jmp;
  endtask

  task automatic drive2(input instr_t b, input logic br, input logic pcs, input logic jmp);
    ifc2.RegWriteD = b.rw; ifc2.MemtoRegD = b.m2r; ifc2.MemWriteD = b.mw;
    ifc2.ALUSrcD = b.as;   ifc2.RegDstD = b.rdst;  ifc2.ALUControlD = b.aluc;
    ifc2.RsD = b.rs;       ifc2.RtD = b.rt;        ifc2.RdD = b.rd;
    ifc2.BranchD = br;     ifc2.PCSrcD = pcs;      ifc2.JumpD = jmp;
  endtask

  function automatic logic [63:0] act_hz();
    return 64'({ifc.StallF, ifc.StallD, ifc.FlushE, ifc.PCRedirect, ifc.FlushD});
  endfunction
  function automatic logic [63:0] act_fwd();
    return 64'({ifc.ForwardAE, ifc.ForwardBE, ifc.ForwardAD, ifc.ForwardBD});
  endfunction
  function automatic logic [63:0] act_e();
    return 64'({ifc.RegWriteE, ifc.MemtoRegE, ifc.MemWriteE, ifc.ALUSrcE, ifc.RegDstE,
                ifc.ALUControlE, ifc.RsE, ifc.RtE, ifc.RdE, ifc.WriteRegE});
  endfunction
  function automatic logic [63:0] act_m();
    return 64'({ifc.RegWriteM, ifc.MemtoRegM, ifc.MemWriteM, ifc.WriteRegM});
  endfunction
  function automatic logic [63:0] act_w();
    return 64'({ifc.RegWriteW, ifc.MemtoRegW, ifc.WriteRegW});
  endfunction

  // Model: which forwarding source supplies register src in E.
  function automatic logic [1:0] m_fwd(logic [4:0] src);
    if (src != 0 && q[1].rw && dest(q[1]) == src) return 2'b10;
    if (src != 0 && q[2].rw && dest(q[2]) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_stall(instr_t d, logic br);
    logic lw, bs;
    lw = q[0].m2r && (q[0].rt == d.rs || q[0].rt == d.rt);
    bs = br && ((q[0].rw && (dest(q[0]) == d.rs || dest(q[0]) == d.rt)) ||
                (q[1].m2r && (dest(q[1]) == d.rs || dest(q[1]) == d.rt)));
    return lw || bs;
  endfunction

  task automatic model_reset();
    q.delete();
    repeat (3) q.push_back('0);
    m_cnt = 0;
  endtask

  task automatic model_check(input instr_t d, input logic br, input logic pcs, input logic jmp);
    logic s, r;
    s = m_stall(d, br);
    r = (pcs || jmp) && !s;
    chk("rnd_hazard", act_hz(), 64'({s, s, s, r, r}));
    chk("rnd_fwd", act_fwd(), 64'({m_fwd(q[0].rs), m_fwd(q[0].rt),
        d.rs != 0 && q[1].rw && dest(q[1]) == d.rs,
        d.rt != 0 && q[1].rw && dest(q[1]) == d.rt}));
    chk("rnd_E", act_e(), 64'({q[0], dest(q[0])}));
    chk("rnd_M", act_m(), 64'({q[1].rw, q[1].m2r, q[1].mw, dest(q[1])}));
    chk("rnd_W", act_w(), 64'({q[2].rw, q[2].m2r, dest(q[2])}));
    chk("rnd_cnt", 64'(ifc.stall_cnt), 64'(m_cnt));
    // Advance the model by one clock.
    q.push_front(s ? instr_t'('0) : d);
    void'(q.pop_back());
    if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  vec_t tbl[16];

  initial begin
    instr_t NOP, LW8, ADD10, ADD3A, ADD3B, ADD7, ADD8, ADD0, ADD9, ADD5, BEQ, rb;
    logic rbr, rpcs, rjmp;
    NOP   = '0;
    LW8   = ins(1, 1, 0, 1, 0, 3'b010, 9, 8, 0);
    ADD10 = ins(1, 0, 0, 0, 1, 3'b010, 8, 11, 10);
    ADD3A = ins(1, 0, 0, 0, 1, 3'b010, 1, 2, 3);
    ADD3B = ins(1, 0, 0, 0, 1, 3'b010, 5, 6, 3);
    ADD7  = ins(1, 0, 0, 0, 1, 3'b010, 3, 3, 7);
    ADD8  = ins(1, 0, 0, 0, 1, 3'b010, 3, 0, 8);
    ADD0  = ins(1, 0, 0, 0, 1, 3'b010, 0, 0, 0);
    ADD9  = ins(1, 0, 0, 0, 1, 3'b010, 0, 0, 9);
    ADD5  = ins(1, 0, 0, 0, 1, 3'b010, 1, 2, 5);
    BEQ   = ins(0, 0, 0, 0, 0, 3'b110, 5, 6, 0);

    //          d      br pcs jmp st rd fae    fbe    fad fbd rwE m2rE wrE rwM wrM cnt
    tbl[0]  = '{LW8,   0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0,  0, 0,  0,  0, 0,  0};
    tbl[1]  = '{ADD10, 0, 0, 0,  1, 0, 2'b00, 2'b00, 0, 0,  1, 1,  8,  0, 0,  0};
    tbl[2]  = '{ADD10, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1, 0,  0, 0,  0,  1, 8,  1};
    tbl[3]  = '{ADD3A, 0, 0, 0,  0, 0, 2'b01, 2'b00, 0, 0,  1, 0,  10, 0, 0,  1};
    tbl[4]  = '{ADD3B, 0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0,  1, 0,  3,  1, 10, 1};
    tbl[5]  = '{ADD7,  0, 0, 0,  0, 0, 2'b00, 2'b00, 1, 1,  1, 0,  3,  1, 3,  1};
    tbl[6]  = '{ADD8,  0, 0, 0,  0, 0, 2'b10, 2'b10, 1, 0,  1, 0,  7,  1, 3,  1};
    tbl[7]  = '{NOP,   0, 0, 0,  0, 0, 2'b01, 2'b00, 0, 0,  1, 0,  8,  1, 7,  1};
    tbl[8]  = '{ADD0,  0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0,  0, 0,  0,  1, 8,  1};
    tbl[9]  = '{ADD9,  0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0,  1, 0,  0,  0, 0,  1};
    tbl[10] = '{NOP,   0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0,  1, 0,  9,  1, 0,  1};
    tbl[11] = '{ADD5,  0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0,  0, 0,  0,  1, 9,  1};
    tbl[12] = '{BEQ,   1, 1, 0,  1, 0, 2'b00, 2'b00, 0, 0,  1, 0,  5,  0, 0,  1};
    tbl[13] = '{BEQ,   1, 1, 0,  0, 1, 2'b00, 2'b00, 1, 0,  0, 0,  0,  1, 5,  2};
    tbl[14] = '{NOP,   0, 0, 1,  0, 1, 2'b01, 2'b00, 0, 0,  0, 0,  6,  0, 0,  2};
    tbl[15] = '{NOP,   0, 0, 0,  0, 0, 2'b00, 2'b00, 0, 0,  0, 0,  0,  0, 6,  2};

    // Reset state.
    rst = 1'b1;
    drive(NOP, 0, 0, 0);
    drive2(NOP, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hazard", act_hz(), 64'd0);
    chk("reset_fwd", act_fwd(), 64'd0);
    chk("reset_E", act_e(), 64'd0);
    chk("reset_MW", {act_m(), act_w()} , 128'd0);
    chk("reset_cnt", 64'(ifc.stall_cnt), 64'd0);
    rst = 1'b0;

    // Hand-computed vector table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].d, tbl[i].br, tbl[i].pcs, tbl[i].jmp);
      #2;
      chk($sformatf("tbl%0d_hazard", i), act_hz(),
          64'({tbl[i].stall, tbl[i].stall, tbl[i].stall, tbl[i].redir, tbl[i].redir}));
      chk($sformatf("tbl%0d_fwd", i), act_fwd(),
          64'({tbl[i].fae, tbl[i].fbe, tbl[i].fad, tbl[i].fbd}));
      chk($sformatf("tbl%0d_E", i), 64'({ifc.RegWriteE, ifc.MemtoRegE, ifc.WriteRegE}),
          64'({tbl[i].rwE, tbl[i].m2rE, tbl[i].wrE}));
      chk($sformatf("tbl%0d_M", i), 64'({ifc.RegWriteM, ifc.WriteRegM}),
          64'({tbl[i].rwM, tbl[i].wrM}));
      chk($sformatf("tbl%0d_cnt", i), 64'(ifc.stall_cnt), 64'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-stream with a writer in M.
    drive(LW8, 0, 0, 0);
    @(posedge clk); #1;
    drive(NOP, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre_reset_RegWriteM", 64'(ifc.RegWriteM), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_E", act_e(), 64'd0);
    chk("async_reset_MW", {act_m(), act_w()}, 128'd0);
    chk("async_reset_hz_fwd", {act_hz(), act_fwd()}, 128'd0);
    chk("async_reset_cnt", 64'(ifc.stall_cnt), 64'd0);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Saturating counter with a 2-bit width: five stalled cycles.
    for (int k = 0; k < 5; k++) begin
      drive2(LW8, 0, 0, 0);
      @(posedge clk); #1;
      drive2(ADD10, 0, 0, 0);
      #2;
      chk($sformatf("sat%0d_stall", k), 64'(ifc2.StallD), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_cnt", k), 64'(ifc2.stall_cnt), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    drive2(NOP, 0, 0, 0);

    // Random traffic against the model; small register range for hazards.
    for (int n = 0; n < 400; n++) begin
      rb.rw   = 1'($urandom_range(0, 1));
      rb.m2r  = ($urandom_range(0, 3) == 0);
      rb.mw   = 1'($urandom_range(0, 1));
      rb.as   = 1'($urandom_range(0, 1));
      rb.rdst = 1'($urandom_range(0, 1));
      rb.aluc = 3'($urandom_range(0, 7));
      rb.rs   = 5'($urandom_range(0, 3));
      rb.rt   = 5'($urandom_range(0, 3));
      rb.rd   = 5'($urandom_range(0, 3));
      rbr     = ($urandom_range(0, 2) == 0);
      rpcs    = rbr && 1'($urandom_range(0, 1));
      rjmp    = ($urandom_range(0, 9) == 0);
      drive(rb, rbr, rpcs, rjmp);
      #2;
      model_check(rb, rbr, rpcs, rjmp);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Downstream consumer of the decode-stage control bundle.
- Carries the decoded control bits and register numbers through the E, M and W pipeline registers.
- Detects load-use and branch-operand hazards, and generates the stall, flush and forwarding selects.
- Gates the decode-stage redirect so a stalled branch never redirects the PC.
- Sits between the decode-stage controller and the datapath stage registers and muxes.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode-stage control bits.
- ALUControlD  in  3  decode-stage ALU operation.
- BranchD  in  1  decode stage holds a beq.
- PCSrcD  in  1  branch taken, from decode compare.
- JumpD  in  1  decode stage holds a jump.
- RsD, RtD, RdD  in  REG_W  decode-stage register fields.
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  E-stage control.
- ALUControlE  out  3  E-stage ALU operation.
- RsE, RtE, RdE  out  REG_W  E-stage register fields.
- WriteRegE  out  REG_W  E-stage destination register.
- RegWriteM, MemtoRegM, MemWriteM  out  1 each  M-stage control.
- WriteRegM  out  REG_W  M-stage destination register.
- RegWriteW, MemtoRegW  out  1 each  W-stage control.
- WriteRegW  out  REG_W  W-stage destination register.
- StallF, StallD  out  1 each  hold the PC and the IF/ID register.
- FlushD  out  1  clear the IF/ID register.
- FlushE  out  1  insert a bubble into E.
- PCRedirect  out  1  take the branch or jump target.
- ForwardAD, ForwardBD  out  1 each  forward ALUOutM to the decode compare.
- ForwardAE, ForwardBE  out  2 each  E operand select: 00 = register file, 01 = ResultW, 10 = ALUOutM.
- stall_cnt  out  CNT_W  count of stalled cycles.

Behaviour:
- Reset (async, rst=1):
  - All E, M and W registers clear to 0, including register fields, so the pipeline holds bubbles.
  - stall_cnt clears to 0.
  - Combinational outputs follow from the zeroed state: all stalls, flushes, redirects and forwards are 0.
  - Reset asserted mid-operation discards all in-flight control immediately.
- Destination selection:
  - WriteRegE = RegDstE ? RdE : RtE (combinational).
  - WriteRegM and WriteRegW are WriteRegE and WriteRegM delayed by one cycle each.
- Pipeline advance, every rising edge:
  - E ← D bundle, unless FlushE=1, in which case all E fields load 0.
  - M ← E, always.
  - W ← M, always.
  - The E, M and W registers are never stalled.
- Hazard detection (combinational):
  - lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
  - branchstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
  - StallF = StallD = FlushE = lwstall | branchstall.
- Redirect:
  - PCRedirect = (PCSrcD | JumpD) & ~StallD.
  - FlushD = PCRedirect.
  - Simultaneous stall and branch: the stall wins, no redirect occurs, and the branch re-evaluates next cycle.
- Forwarding:
  - ForwardAE = 10 if RsE!=0 & RegWriteM & RsE==WriteRegM.
  - Otherwise ForwardAE = 01 if RsE!=0 & RegWriteW & RsE==WriteRegW.
  - Otherwise ForwardAE = 00.
  - M has priority over W. ForwardBE follows the same rules using RtE.
  - ForwardAD = RsD!=0 & RegWriteM & RsD==WriteRegM; ForwardBD is the same using RtD.
  - Register 0 never forwards.
- stall_cnt increments on each edge where StallD=1 and saturates at 2^CNT_W-1 (no wrap).

Test Plan:
- lw $8 in E (MemtoRegE=1, RtE=8) while D holds add with RsD=8 -> StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle E is all-zero; stall_cnt increments by 1.
- add $3 in M (RegWriteM=1, WriteRegM=3) and add $3 in W, with E having RsE=3 -> ForwardAE=10. Remove the M writer -> ForwardAE=01. Set RsE=0 with writer WriteReg=0 -> ForwardAE=00.
- beq with RsD=5 while E writes $5 (RegWriteE=1, WriteRegE=5), PCSrcD=1 -> StallD=1 and PCRedirect=0. Next cycle, with the producer now in M -> no stall, ForwardAD=1, PCRedirect=1, FlushD=1.
- JumpD=1 with no hazard -> PCRedirect=1, FlushD=1, StallF=0.
- Assert rst asynchronously mid-stream with RegWriteM=1 -> all outputs 0 before the next edge; stall_cnt=0.
- CNT_W=2 with StallD held for 5 cycles -> stall_cnt reaches 3 and stays at 3.
